// File: rtl/unified_mem_arbiter_pkg.sv
// Shared definitions for the unified IF/MEM memory arbiter.
//   arb_state_e   : arbiter FSM encoding
//   owner_e       : which requester owns the in-flight read
//   is_misaligned : byte-offset check on a requester address
package unified_mem_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_MEM = 1'b1
   } owner_e;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the word RAM.
//   slave  : arbiter side (takes requests and RAM read data, drives grants,
//            read returns, stalls and the RAM strobes)
//   master : requester/RAM side (mirror image)
interface unified_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int RAM_AW = 10
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [31:0]       if_rdata;
   logic              if_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_stall;

   logic              misalign;

   logic              ram_en;
   logic              ram_we;
   logic [RAM_AW-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   modport slave (
      input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, if_stall,
             mem_gnt, mem_rvalid, mem_rdata, mem_stall,
             misalign, ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_stall,
             mem_gnt, mem_rvalid, mem_rdata, mem_stall,
             misalign, ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter_starve.sv
// Saturating counter of IF losses used to break MEM-over-IF priority.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : count one more loss (held at LIMIT once reached)
//   clr_i      : clear (takes precedence over inc_i)
//   full_o     : count equals LIMIT
module arb_starve_counter #(
   parameter int LIMIT = 4,
   parameter int W     = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic full_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign full_o = (cnt_q == W'(LIMIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !full_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous word RAM between instruction fetch (IF)
// and load/store (MEM). Grants are combinational in IDLE; reads hold the FSM
// in BUSY for RD_LAT cycles and return data with a one-cycle rvalid pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : requester handshakes, stalls, misalign and RAM strobes
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ARB_IDLE | RAM free; grant MEM (or starved IF); stores finish here
//   ARB_BUSY | read in flight for owner_q; lat_q counts down the RAM latency
module unified_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int RAM_AW       = 10,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   unified_mem_arbiter_if.slave bus
);
   import unified_mem_arbiter_pkg::*;

   localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LAT - 1);

   arb_state_e       state_q, state_d;
   owner_e           owner_q, owner_d;
   logic [LAT_W-1:0] lat_q, lat_d;

   logic             if_rvalid_q, if_rvalid_d;
   logic             mem_rvalid_q, mem_rvalid_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      mem_rdata_q, mem_rdata_d;

   logic             if_wins;
   logic             if_gnt;
   logic             mem_gnt;
   logic             starve_full;

   // Upper address bits address outside the RAM and are intentionally ignored.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr[ADDR_W-1:RAM_AW+2],
                               bus.mem_addr[ADDR_W-1:RAM_AW+2]};

   // Only IF losses while IF is actually waiting count toward starvation.
   arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (mem_gnt & bus.if_req),
      .clr_i  (if_gnt),
      .full_o (starve_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ARB_IDLE;
         owner_q <= OWNER_IF;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lat_q   <= lat_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_rvalid_q  <= 1'b0;
         mem_rvalid_q <= 1'b0;
         if_rdata_q   <= '0;
         mem_rdata_q  <= '0;
      end else begin
         if_rvalid_q  <= if_rvalid_d;
         mem_rvalid_q <= mem_rvalid_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_d        = lat_q;
      if_rvalid_d  = 1'b0;
      mem_rvalid_d = 1'b0;
      if_rdata_d   = if_rdata_q;
      mem_rdata_d  = mem_rdata_q;
      case (state_q)
         ARB_IDLE: begin
            // Stores complete in the grant cycle, so only reads leave IDLE.
            if (if_gnt || (mem_gnt && !bus.mem_we)) begin
               state_d = ARB_BUSY;
               owner_d = if_gnt ? OWNER_IF : OWNER_MEM;
               lat_d   = LAT_LOAD;
            end
         end
         ARB_BUSY: begin
            if (lat_q == '0) begin
               state_d = ARB_IDLE;
               if (owner_q == OWNER_IF) begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = bus.ram_rdata;
               end else begin
                  mem_rvalid_d = 1'b1;
                  mem_rdata_d  = bus.ram_rdata;
               end
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // MEM normally wins (older instruction); a starved IF takes one tie.
   always_comb begin
      if_wins = bus.if_req & (~bus.mem_req | starve_full);
      if_gnt  = (state_q == ARB_IDLE) & if_wins;
      mem_gnt = (state_q == ARB_IDLE) & bus.mem_req & ~if_wins;
   end

   assign bus.if_gnt     = if_gnt;
   assign bus.mem_gnt    = mem_gnt;
   assign bus.if_rvalid  = if_rvalid_q;
   assign bus.mem_rvalid = mem_rvalid_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.mem_rdata  = mem_rdata_q;

   assign bus.if_stall  = bus.if_req & ~if_rvalid_q;
   assign bus.mem_stall = bus.mem_req & ~(bus.mem_we ? mem_gnt : mem_rvalid_q);

   assign bus.misalign = (if_gnt  & is_misaligned(bus.if_addr[1:0]))
                       | (mem_gnt & is_misaligned(bus.mem_addr[1:0]));

   assign bus.ram_en    = if_gnt | mem_gnt;
   assign bus.ram_we    = mem_gnt & bus.mem_we;
   assign bus.ram_addr  = mem_gnt ? bus.mem_addr[RAM_AW+1:2] : bus.if_addr[RAM_AW+1:2];
   assign bus.ram_wdata = bus.mem_wdata;

   // The owner must keep requesting until its read data returns.
   req_held_a: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ARB_BUSY) |-> ((owner_q == OWNER_IF) ? bus.if_req : bus.mem_req));

endmodule
